// File: rtl/controller_pkg.sv
// Shared encodings for the controller and datapath: state codes, ALU select
// and operation codes, and the opcode/extension values of the instruction set.
package cpu_definitions;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'b000,
    ST_DECODE    = 3'b001,
    ST_EXECUTE   = 3'b010,
    ST_WRITEBACK = 3'b011
  } state_t;

  typedef enum logic [1:0] {
    ALU_A_PC       = 2'b00,
    ALU_A_SRC      = 2'b01,
    ALU_A_IMM_SEXT = 2'b10,
    ALU_A_IMM_ZEXT = 2'b11
  } alu_a_sel_t;

  typedef enum logic {
    ALU_B_DST = 1'b0,
    ALU_B_ONE = 1'b1
  } alu_b_sel_t;

  // ALU_RSVD exists only so the datapath can decode all four codes.
  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_CMP  = 2'b10,
    ALU_RSVD = 2'b11
  } alu_op_t;

  localparam logic [3:0] OPC_REGISTER = 4'b0000;
  localparam logic [3:0] OPC_ADDI     = 4'b0101;
  localparam logic [3:0] OPC_SUBI     = 4'b1001;
  localparam logic [3:0] OPC_CMPI     = 4'b1011;

  localparam logic [3:0] EXT_ADD = 4'b0101;
  localparam logic [3:0] EXT_SUB = 4'b1001;
  localparam logic [3:0] EXT_CMP = 4'b1011;

  function automatic logic [3:0] opcode_of(input logic [15:0] instruction);
    return instruction[15:12];
  endfunction

  function automatic logic [3:0] extension_of(input logic [15:0] instruction);
    return instruction[7:4];
  endfunction

  function automatic alu_a_sel_t execute_a_select(input logic immediate_form);
    alu_a_sel_t sel;
    if (immediate_form) sel = ALU_A_IMM_SEXT;
    else                sel = ALU_A_SRC;
    return sel;
  endfunction

endpackage

// File: rtl/controller_if.sv
// Controller <-> datapath bundle: instruction fetch handshake in, ALU selects
// and write strobes out, plus the current state for observation.
interface controller_if;

  logic        memory_ready;
  logic [15:0] instruction;
  logic [1:0]  alu_a_select;
  logic        alu_b_select;
  logic [1:0]  alu_operation;
  logic        program_counter_write_enable;
  logic        instruction_write_enable;
  logic        status_write_enable;
  logic        register_write_enable;
  logic        illegal_instruction;
  logic [2:0]  state;

  modport master (
    input  memory_ready,
    input  instruction,
    output alu_a_select,
    output alu_b_select,
    output alu_operation,
    output program_counter_write_enable,
    output instruction_write_enable,
    output status_write_enable,
    output register_write_enable,
    output illegal_instruction,
    output state
  );

  modport slave (
    output memory_ready,
    output instruction,
    input  alu_a_select,
    input  alu_b_select,
    input  alu_operation,
    input  program_counter_write_enable,
    input  instruction_write_enable,
    input  status_write_enable,
    input  register_write_enable,
    input  illegal_instruction,
    input  state
  );

endinterface

// File: rtl/controller_decoder.sv
// Combinational instruction classifier: legality, operand form, whether the
// result is written back, and the ALU operation to perform.
module instruction_decoder
  import cpu_definitions::*;
(
  input  logic [15:0] instruction,
  output logic        legal,
  output logic        immediate_form,
  output logic        writes_register,
  output alu_op_t     alu_operation
);

  logic [3:0] opcode;
  logic [3:0] extension;
  logic       unused_fields;

  assign opcode    = opcode_of(instruction);
  assign extension = extension_of(instruction);
  // Register numbers and immediates belong to the datapath, not to decode.
  assign unused_fields = ^{instruction[11:8], instruction[3:0]};

  always_comb begin
    legal          = 1'b0;
    immediate_form = 1'b0;
    alu_operation  = ALU_ADD;
    case (opcode)
      OPC_REGISTER: begin
        case (extension)
          EXT_ADD: begin legal = 1'b1; alu_operation = ALU_ADD; end
          EXT_SUB: begin legal = 1'b1; alu_operation = ALU_SUB; end
          EXT_CMP: begin legal = 1'b1; alu_operation = ALU_CMP; end
          default: ;
        endcase
      end
      OPC_ADDI: begin legal = 1'b1; immediate_form = 1'b1; alu_operation = ALU_ADD; end
      OPC_SUBI: begin legal = 1'b1; immediate_form = 1'b1; alu_operation = ALU_SUB; end
      OPC_CMPI: begin legal = 1'b1; immediate_form = 1'b1; alu_operation = ALU_CMP; end
      default: ;
    endcase
    writes_register = legal && (alu_operation != ALU_CMP);
  end

endmodule

// File: rtl/controller.sv
// Multi-cycle Moore controller: FETCH -> DECODE -> EXECUTE -> WRITEBACK,
// with compares skipping WRITEBACK and illegal instructions aborting in DECODE.
module controller
  import cpu_definitions::*;
(
  input  logic         clock,
  input  logic         reset,
  controller_if.master bus
);

  state_t     state_q, state_d;

  logic       dec_legal;
  logic       dec_immediate;
  logic       dec_writes_register;
  alu_op_t    dec_operation;

  alu_a_sel_t a_sel;
  alu_b_sel_t b_sel;
  alu_op_t    alu_op;
  logic       pc_we, ir_we, status_we, reg_we, illegal;

  instruction_decoder u_decoder (
    .instruction     (bus.instruction),
    .legal           (dec_legal),
    .immediate_form  (dec_immediate),
    .writes_register (dec_writes_register),
    .alu_operation   (dec_operation)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = ST_FETCH;
    a_sel     = ALU_A_PC;
    b_sel     = ALU_B_ONE;
    alu_op    = ALU_ADD;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    status_we = 1'b0;
    reg_we    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        pc_we   = bus.memory_ready;
        ir_we   = bus.memory_ready;
        state_d = bus.memory_ready ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        if (dec_legal) state_d = ST_EXECUTE;
        else           illegal = 1'b1;
      end
      ST_EXECUTE: begin
        a_sel     = execute_a_select(dec_immediate);
        b_sel     = ALU_B_DST;
        alu_op    = dec_operation;
        status_we = 1'b1;
        state_d   = dec_writes_register ? ST_WRITEBACK : ST_FETCH;
      end
      ST_WRITEBACK: begin
        // The instruction register is stable, so the EXECUTE selects recompute unchanged.
        a_sel  = execute_a_select(dec_immediate);
        b_sel  = ALU_B_DST;
        alu_op = dec_operation;
        reg_we = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset gates the outputs directly so strobes drop without waiting for a clock.
  assign bus.alu_a_select                 = reset ? a_sel  : ALU_A_PC;
  assign bus.alu_b_select                 = reset ? b_sel  : ALU_B_ONE;
  assign bus.alu_operation                = reset ? alu_op : ALU_ADD;
  assign bus.program_counter_write_enable = reset & pc_we;
  assign bus.instruction_write_enable     = reset & ir_we;
  assign bus.status_write_enable          = reset & status_we;
  assign bus.register_write_enable        = reset & reg_we;
  assign bus.illegal_instruction          = reset & illegal;
  assign bus.state                        = state_q;

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for the controller: per-cycle expected outputs are queued
// as instructions are driven and compared on the falling clock edge.
module tb_controller;

  logic clock = 1'b0;
  logic reset;

  controller_if bus ();

  controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [12:0] val;
    logic [12:0] mask;
    string       tag;
  } exp_t;

  exp_t sb[$];

  // Packed layout: {state[2:0], a[1:0], b, op[1:0], pcwe, iwe, swe, rwe, ill}
  localparam logic [12:0] M_ALL = 13'h1FFF;
  localparam logic [12:0] M_DEC = 13'b111_00_0_00_11111;

  localparam int K_ADD = 0;
  localparam int K_SUB = 1;
  localparam int K_CMP = 2;
  localparam int K_ILL = 3;

  function automatic logic [12:0] observed();
    return {bus.state, bus.alu_a_select, bus.alu_b_select, bus.alu_operation,
            bus.program_counter_write_enable, bus.instruction_write_enable,
            bus.status_write_enable, bus.register_write_enable,
            bus.illegal_instruction};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_cycle(input string tag, input logic [2:0] st, input logic [1:0] a,
                              input logic b, input logic [1:0] op, input logic [4:0] strb,
                              input logic [12:0] mask);
    exp_t e;
    e.val  = {st, a, b, op, strb};
    e.mask = mask;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin : cmp
      exp_t e;
      e = sb.pop_front();
      check_eq(e.tag, {19'd0, observed() & e.mask}, {19'd0, e.val & e.mask});
    end
  end

  task automatic run_instr(input logic [15:0] ins, input int kind, input logic imm, input int waits);
    logic [1:0] a_exp;
    a_exp = imm ? 2'b10 : 2'b01;
    bus.instruction = ins;
    for (int i = 0; i < waits; i++) begin
      bus.memory_ready = 1'b0;
      expect_cycle($sformatf("fetch_wait_%h", ins), 3'b000, 2'b00, 1'b1, 2'b00, 5'b00000, M_ALL);
      step();
    end
    bus.memory_ready = 1'b1;
    expect_cycle($sformatf("fetch_ready_%h", ins), 3'b000, 2'b00, 1'b1, 2'b00, 5'b11000, M_ALL);
    step();
    bus.memory_ready = 1'($urandom_range(0, 1));
    if (kind == K_ILL) begin
      expect_cycle($sformatf("decode_illegal_%h", ins), 3'b001, 2'b00, 1'b0, 2'b00, 5'b00001, M_DEC);
      step();
    end else begin
      expect_cycle($sformatf("decode_%h", ins), 3'b001, 2'b00, 1'b0, 2'b00, 5'b00000, M_DEC);
      step();
      bus.memory_ready = 1'($urandom_range(0, 1));
      expect_cycle($sformatf("execute_%h", ins), 3'b010, a_exp, 1'b0, 2'(kind), 5'b00100, M_ALL);
      step();
      if (kind != K_CMP) begin
        bus.memory_ready = 1'($urandom_range(0, 1));
        expect_cycle($sformatf("writeback_%h", ins), 3'b011, a_exp, 1'b0, 2'(kind), 5'b00010, M_ALL);
        step();
      end
    end
  endtask

  typedef struct {
    logic [15:0] ins;
    int          kind;
    logic        imm;
    int          waits;
  } stim_t;

  stim_t program_table[12];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    program_table[0]  = '{16'h0351, K_ADD, 1'b0, 3};
    program_table[1]  = '{16'h52FF, K_ADD, 1'b1, 0};
    program_table[2]  = '{16'hB205, K_CMP, 1'b1, 0};
    program_table[3]  = '{16'h03B1, K_CMP, 1'b0, 1};
    program_table[4]  = '{16'hF000, K_ILL, 1'b0, 0};
    program_table[5]  = '{16'h0371, K_ILL, 1'b0, 0};
    program_table[6]  = '{16'h0391, K_SUB, 1'b0, 2};
    program_table[7]  = '{16'h92A0, K_SUB, 1'b1, 0};
    program_table[8]  = '{16'h0000, K_ILL, 1'b0, 1};
    program_table[9]  = '{16'h5F5F, K_ADD, 1'b1, 0};
    program_table[10] = '{16'h1051, K_ILL, 1'b0, 0};
    program_table[11] = '{16'h0AB7, K_CMP, 1'b0, 0};

    bus.memory_ready = 1'b1;
    bus.instruction  = 16'h0351;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check_eq("reset_state", {29'd0, bus.state}, 32'd0);
    check_eq("reset_strobes", {27'd0, observed() & 13'h1F}, 32'd0);
    check_eq("reset_selects", {27'd0, observed()[9:5]}, {27'd0, 5'b00_1_00});
    repeat (2) @(posedge clock);
    #1;
    check_eq("reset_hold_state", {29'd0, bus.state}, 32'd0);
    reset = 1'b1;

    foreach (program_table[i])
      run_instr(program_table[i].ins, program_table[i].kind, program_table[i].imm, program_table[i].waits);

    // Reset asserted in the middle of EXECUTE of an ADD
    bus.instruction  = 16'h0351;
    bus.memory_ready = 1'b1;
    expect_cycle("mid_fetch", 3'b000, 2'b00, 1'b1, 2'b00, 5'b11000, M_ALL);
    step();
    expect_cycle("mid_decode", 3'b001, 2'b00, 1'b0, 2'b00, 5'b00000, M_DEC);
    step();
    expect_cycle("mid_execute", 3'b010, 2'b01, 1'b0, 2'b00, 5'b00100, M_ALL);
    #5;
    reset = 1'b0;
    #1;
    check_eq("midreset_state", {29'd0, bus.state}, 32'd0);
    check_eq("midreset_strobes", {27'd0, observed() & 13'h1F}, 32'd0);
    check_eq("midreset_selects", {27'd0, observed()[9:5]}, {27'd0, 5'b00_1_00});
    step();
    check_eq("midreset_hold", {19'd0, observed()}, {19'd0, 13'b000_00_1_00_00000});
    reset = 1'b1;
    run_instr(16'h0351, K_ADD, 1'b0, 0);
    run_instr(16'hB205, K_CMP, 1'b1, 1);

    bus.memory_ready = 1'b0;
    step();
    check_eq("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
